// File: rtl/hold_bus_arbiter_pkg.sv
// hold_bus_pkg: shared definitions for the HOLD/HOLD_ACK bus arbiter.
//   state_t          arbiter FSM state encoding
//   OWNER_CPU        owner code reported while the CPU owns the bus
//   DEFAULT_MAX_HOLD default grant-cycle limit before the timeout flag is raised
package hold_bus_pkg;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [2:0] OWNER_CPU        = 3'd0;
  localparam int         DEFAULT_MAX_HOLD = 4096;

endpackage

// File: rtl/hold_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   per-requester request vector
//   ptr   index with the highest priority this round
//   valid some request is set
//   idx   first set request at or after ptr, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  always_comb begin
    int j;
    logic [PW-1:0] k;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    k     = '0;
    // Scan from the farthest offset down so the requester nearest ptr is the last writer.
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      k = PW'(j);
      if (req[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/hold_bus_arbiter.sv
// hold_bus_arbiter: hands the shared data-memory port from the CPU to one of
// NREQ DMA masters using the HOLD/HOLD_ACK handshake.
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_we/addr/wdata/mem_busy     CPU access and its in-flight indication
//   cpu_stall                      freezes the CPU pipeline (registered)
//   hold_req / hold_ack            per-requester HOLD level / one-hot HOLD_ACK
//   dma_we/addr/wdata              per-requester access, flattened k*W +: W
//   mem_we/addr/wdata              muxed memory port
//   owner                          0 = CPU, k+1 = requester k
//   timeout / timeout_clr          sticky hold-time violation flag and its clear
module hold_bus_arbiter
  import hold_bus_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  input  logic               cpu_mem_busy,
  output logic               cpu_stall,
  input  logic [NREQ-1:0]    hold_req,
  output logic [NREQ-1:0]    hold_ack,
  input  logic [NREQ-1:0]    dma_we,
  input  logic [NREQ*AW-1:0] dma_addr,
  input  logic [NREQ*DW-1:0] dma_wdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [2:0]         owner,
  output logic               timeout,
  input  logic               timeout_clr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] ptr_after;
  logic [CW-1:0] hold_cnt;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          hold_hit;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (hold_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // With NREQ == 1 the winner is always the last index, so the pointer stays 0.
  assign ptr_after = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;

  // Fires only on the cycle the counter steps onto MAX_HOLD; a clear afterwards sticks.
  assign hold_hit = (state == GRANT) && (hold_cnt == HOLD_LIMIT - 1'b1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CPU_OWN;
      cpu_stall <= 1'b0;
      hold_ack  <= '0;
      owner     <= OWNER_CPU;
      rr_ptr    <= '0;
      winner    <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      if (hold_hit)         timeout <= 1'b1;
      else if (timeout_clr) timeout <= 1'b0;

      case (state)
        CPU_OWN: begin
          if (|hold_req) begin
            state     <= DRAIN;
            cpu_stall <= 1'b1;
          end
        end
        DRAIN: begin
          if (!(|hold_req)) begin
            state     <= CPU_OWN;
            cpu_stall <= 1'b0;
          end else if (!cpu_mem_busy && pick_valid) begin
            winner   <= pick_idx;
            hold_ack <= NREQ'(1) << pick_idx;
            owner    <= 3'(pick_idx) + 3'd1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_LIMIT) hold_cnt <= hold_cnt + 1'b1;
          if (!hold_req[winner]) begin
            hold_ack <= '0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr <= ptr_after;
          owner  <= OWNER_CPU;
          // Pending requests go straight back to DRAIN: the CPU gets no window.
          if (|hold_req) begin
            state <= DRAIN;
          end else begin
            state     <= CPU_OWN;
            cpu_stall <= 1'b0;
          end
        end
        default: state <= CPU_OWN;
      endcase
    end
  end

  // Memory port mux; in reset the state is CPU_OWN so the CPU passes through.
  always_comb begin
    mem_we    = cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (state)
      GRANT: begin
        mem_we    = dma_we[winner];
        mem_addr  = dma_addr[int'(winner)*AW +: AW];
        mem_wdata = dma_wdata[int'(winner)*DW +: DW];
      end
      RELEASE: mem_we = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hold_bus_arbiter.sv
// tb_hold_bus_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_hold_bus_arbiter;

  localparam int NREQ     = 2;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cpu_we;
  logic [AW-1:0]      cpu_addr;
  logic [DW-1:0]      cpu_wdata;
  logic               cpu_mem_busy;
  logic               cpu_stall;
  logic [NREQ-1:0]    hold_req;
  logic [NREQ-1:0]    hold_ack;
  logic [NREQ-1:0]    dma_we;
  logic [NREQ*AW-1:0] dma_addr;
  logic [NREQ*DW-1:0] dma_wdata;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [2:0]         owner;
  logic               timeout;
  logic               timeout_clr;

  logic [AW-1:0] d_addr  [NREQ];
  logic [DW-1:0] d_wdata [NREQ];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      dma_addr[k*AW +: AW]  = d_addr[k];
      dma_wdata[k*DW +: DW] = d_wdata[k];
    end
  end

  hold_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_mem_busy (cpu_mem_busy),
    .cpu_stall    (cpu_stall),
    .hold_req     (hold_req),
    .hold_ack     (hold_ack),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .owner        (owner),
    .timeout      (timeout),
    .timeout_clr  (timeout_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: who holds the bus, whether a release cycle is in progress,
  // whether the CPU is stalled, plus round-robin pointer and grant-cycle count.
  typedef struct {
    int grant;   // granted requester, -1 when none
    int last;    // requester being released, -1 when none
    int cnt;     // grant cycles so far, saturating
    int ptr;     // round-robin start index
    bit stall;
    bit rel;
    bit tmo;
  } model_t;

  function automatic model_t reset_model();
    model_t r;
    r.grant = -1; r.last = -1; r.cnt = 0; r.ptr = 0;
    r.stall = 1'b0; r.rel = 1'b0; r.tmo = 1'b0;
    return r;
  endfunction

  function automatic model_t step(input model_t s, input logic [NREQ-1:0] req,
                                  input logic busy, input logic clr);
    model_t n;
    bit hit;
    n   = s;
    hit = 1'b0;
    if (s.grant >= 0) begin
      if (s.cnt < MAX_HOLD) begin
        n.cnt = s.cnt + 1;
        hit   = (n.cnt == MAX_HOLD);
      end
      if (!req[s.grant]) begin
        n.last  = s.grant;
        n.grant = -1;
        n.rel   = 1'b1;
      end
    end else if (s.rel) begin
      n.ptr   = (s.last + 1) % NREQ;
      n.rel   = 1'b0;
      n.last  = -1;
      n.stall = (req != 0);
    end else if (s.stall) begin
      if (req == 0) n.stall = 1'b0;
      else if (!busy) begin
        for (int k = 0; k < NREQ; k++)
          if (n.grant < 0 && req[(s.ptr + k) % NREQ]) n.grant = (s.ptr + k) % NREQ;
        n.cnt = 0;
      end
    end else if (req != 0) begin
      n.stall = 1'b1;
    end
    if (hit)      n.tmo = 1'b1;
    else if (clr) n.tmo = 1'b0;
    return n;
  endfunction

  model_t m = '{grant: -1, last: -1, cnt: 0, ptr: 0, stall: 1'b0, rel: 1'b0, tmo: 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) m <= reset_model();
    else     m <= step(m, hold_req, cpu_mem_busy, timeout_clr);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e_ack, e_owner, e_we, e_addr, e_wdata;
    e_ack   = (m.grant >= 0) ? (64'd1 << m.grant) : 64'd0;
    e_owner = (m.grant >= 0) ? 64'(m.grant + 1) : (m.rel ? 64'(m.last + 1) : 64'd0);
    e_we    = cpu_we;
    e_addr  = cpu_addr;
    e_wdata = cpu_wdata;
    if (m.grant >= 0) begin
      e_we    = dma_we[m.grant];
      e_addr  = d_addr[m.grant];
      e_wdata = d_wdata[m.grant];
    end else if (m.rel) begin
      e_we = 64'd0;
    end
    check("cpu_stall", cpu_stall, m.stall);
    check("hold_ack",  hold_ack,  e_ack);
    check("owner",     owner,     e_owner);
    check("timeout",   timeout,   m.tmo);
    check("mem_we",    mem_we,    e_we);
    check("mem_addr",  mem_addr,  e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
  end

  initial begin
    cpu_we       = 1'b0;
    cpu_addr     = 32'h0000_C000;
    cpu_wdata    = 32'h5555_5555;
    cpu_mem_busy = 1'b0;
    hold_req     = '0;
    dma_we       = '0;
    timeout_clr  = 1'b0;
    d_addr[0]    = 32'h0000_1000;
    d_addr[1]    = 32'h0000_2000;
    d_wdata[0]   = 32'hAAAA_0000;
    d_wdata[1]   = 32'hBBBB_1111;

    // Reset state
    tick(2);
    check("rst_hold_ack", hold_ack, 0);
    check("rst_owner", owner, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_timeout", timeout, 0);
    check("rst_mem_addr", mem_addr, 32'h0000_C000);
    rst = 1'b0;
    tick(2);

    // Single request: cycle 0 request, stall at 1, ack at 2, drop at 10
    hold_req = 2'b01;
    tick();
    check("single_stall_c1", cpu_stall, 1);
    check("single_ack_c1", hold_ack, 2'b00);
    tick();
    check("single_ack_c2", hold_ack, 2'b01);
    check("single_owner_c2", owner, 1);
    check("single_mem_addr_c2", mem_addr, 32'h0000_1000);
    tick(8);
    hold_req = 2'b00;
    tick();
    check("single_ack_c11", hold_ack, 2'b00);
    check("single_stall_c11", cpu_stall, 1);
    tick();
    check("single_stall_c12", cpu_stall, 0);
    check("single_owner_c12", owner, 0);
    tick(2);

    // Drain wait: CPU busy for 5 cycles holds off the grant
    cpu_mem_busy = 1'b1;
    hold_req     = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("drain_ack_held", hold_ack, 2'b00);
      check("drain_mem_cpu", mem_addr, 32'h0000_C000);
    end
    cpu_mem_busy = 1'b0;
    tick();
    check("drain_ack_after_busy", hold_ack, 2'b01);
    hold_req = 2'b00;
    tick(3);

    // Withdraw in DRAIN
    cpu_mem_busy = 1'b1;
    hold_req     = 2'b10;
    tick();
    check("withdraw_stall_c1", cpu_stall, 1);
    hold_req = 2'b00;
    tick();
    check("withdraw_stall_c2", cpu_stall, 0);
    check("withdraw_ack_c2", hold_ack, 2'b00);
    tick();
    check("withdraw_stall_c3", cpu_stall, 0);
    cpu_mem_busy = 1'b0;

    // Round-robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hold_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int w;
      logic [NREQ-1:0] exp_ack;
      exp_ack = (g % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      while (hold_ack == 0 && w < 10) begin
        tick();
        w++;
      end
      check("rr_grant", hold_ack, exp_ack);
      check("rr_stall", cpu_stall, 1);
      tick(2);
      hold_req[g % 2] = 1'b0;
      tick();
      hold_req = 2'b11;
      check("rr_release_ack", hold_ack, 2'b00);
      check("rr_release_stall", cpu_stall, 1);
    end
    hold_req = 2'b00;
    tick(4);

    // Timeout: set after 8 grant cycles, sticky, clearable, set beats clear
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("tmo_cleared_start", timeout, 0);
    hold_req = 2'b01;
    tick(2);
    check("tmo_grant", hold_ack, 2'b01);
    tick(7);
    check("tmo_before_limit", timeout, 0);
    tick();
    check("tmo_at_limit", timeout, 1);
    tick(3);
    hold_req = 2'b00;
    tick(3);
    check("tmo_sticky", timeout, 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("tmo_clr", timeout, 0);
    hold_req = 2'b01;
    tick(9);
    timeout_clr = 1'b1;
    tick();
    check("tmo_set_beats_clr", timeout, 1);
    timeout_clr = 1'b0;
    hold_req    = 2'b00;
    tick(3);

    // Asynchronous reset in the middle of a grant
    hold_req = 2'b01;
    dma_we   = 2'b01;
    cpu_we   = 1'b0;
    tick(2);
    check("arst_pre_mem_we", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_hold_ack", hold_ack, 2'b00);
    check("arst_mem_we", mem_we, 0);
    check("arst_stall", cpu_stall, 0);
    check("arst_owner", owner, 0);
    tick();
    hold_req = 2'b00;
    dma_we   = 2'b00;
    rst      = 1'b0;
    tick(2);

    // Randomized traffic, checked every cycle by the model
    repeat (3000) begin
      if ($urandom % 6 == 0) hold_req = NREQ'($urandom);
      cpu_mem_busy = ($urandom % 3 == 0);
      cpu_we       = 1'($urandom);
      cpu_addr     = $urandom;
      cpu_wdata    = $urandom;
      dma_we       = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        d_addr[k]  = $urandom;
        d_wdata[k] = $urandom;
      end
      timeout_clr = ($urandom % 40 == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
